// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC register's next value and hold enable, handles imem
// wait states, redirects and hazard stalls. Define PC_FETCH_PERF_EN to add stall/redirect counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcf,
  input  logic        stall_hazard,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
  input  logic        branch_taken_d,
  input  logic [31:0] branch_target_d,
  input  logic        imem_ready,
  output logic [31:0] pc_next,
  output logic        stall_pc,
  output logic        imem_req,
  output logic        flush_d,
  output logic        imem_timeout
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, REDIR} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [31:0] redir_tgt, redir_tgt_nxt;
  logic [7:0]  wait_cnt, cnt_inc;
  logic [31:0] tgt, pc_raw;
  logic        redirect, counting;

  always_comb begin
    redirect = jump_d | branch_taken_d;
    tgt      = jump_d ? jump_target_d : branch_target_d;
    counting = (state == WAIT || state == REDIR) && !imem_ready;
    cnt_inc  = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
  end

  // NOTE: every output and next-state value gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    redir_tgt_nxt = redir_tgt;
    pc_raw        = pcf;
    stall_pc      = 1'b1;
    imem_req      = 1'b1;
    flush_d       = 1'b0;
    if (rst) begin
      // The PC register has no reset of its own, so it is fed the vector throughout reset.
      pc_raw    = RESET_VEC;
      stall_pc  = 1'b0;
      imem_req  = 1'b0;
      flush_d   = 1'b1;
      state_nxt = BOOT;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (imem_ready) begin
            state_nxt = FETCH;
            if (!stall_hazard) begin
              stall_pc = 1'b0;
              flush_d  = redirect;
              pc_raw   = redirect ? tgt : pcf + 32'd4;
            end
          end else if (redirect && !stall_hazard) begin
            redir_tgt_nxt = tgt;
            state_nxt     = REDIR;
          end else begin
            state_nxt = WAIT;
          end
        end
        REDIR: begin
          // Wrong-path fetch must retire before the PC moves; later redirects are ignored.
          if (imem_ready) begin
            pc_raw    = redir_tgt;
            stall_pc  = 1'b0;
            flush_d   = 1'b1;
            state_nxt = FETCH;
          end
        end
        default: begin
          pc_raw    = RESET_VEC;
          stall_pc  = 1'b0;
          imem_req  = 1'b0;
          flush_d   = 1'b1;
          state_nxt = FETCH;
        end
      endcase
    end
  end

  assign pc_next = {pc_raw[31:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      redir_tgt    <= '0;
      wait_cnt     <= '0;
      imem_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      redir_tgt <= redir_tgt_nxt;
      if (imem_ready) begin
        wait_cnt <= '0;
      end else if (counting) begin
        wait_cnt <= cnt_inc;
      end
      if (counting && cnt_inc >= MAX_WAIT_C) begin
        imem_timeout <= 1'b1;
      end
    end
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else if (state != BOOT) begin
      if (stall_pc) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_d)  perf_redirects    <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural PC register (no reset, loads when not stalled).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        stall_hazard, jump_d, branch_taken_d, imem_ready;
  logic [31:0] jump_target_d, branch_target_d;
  logic [31:0] pc_next;
  logic        stall_pc, imem_req, flush_d, imem_timeout;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_VEC(32'h0000_3000), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .pcf(pcf), .stall_hazard(stall_hazard),
    .jump_d(jump_d), .jump_target_d(jump_target_d),
    .branch_taken_d(branch_taken_d), .branch_target_d(branch_target_d),
    .imem_ready(imem_ready), .pc_next(pc_next), .stall_pc(stall_pc),
    .imem_req(imem_req), .flush_d(flush_d), .imem_timeout(imem_timeout)
  );

  always_ff @(posedge clk) begin
    if (!stall_pc) pcf <= pc_next;
  end

  typedef struct {
    logic        hz, jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        rdy;
    logic [31:0] pcf, pcn;
    logic        stall, req, flush;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic hz, input logic jmp, input logic [31:0] jt,
                              input logic br, input logic [31:0] bt, input logic rdy,
                              input logic [31:0] epcf, input logic [31:0] epcn,
                              input logic est, input logic ereq, input logic efl);
    vec_t v;
    v.hz = hz; v.jmp = jmp; v.jt = jt; v.br = br; v.bt = bt; v.rdy = rdy;
    v.pcf = epcf; v.pcn = epcn; v.stall = est; v.req = ereq; v.flush = efl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic hz, input logic jmp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic rdy);
    stall_hazard = hz; jump_d = jmp; jump_target_d = jt;
    branch_taken_d = br; branch_target_d = bt; imem_ready = rdy;
  endtask

  initial begin
    // After reset: BOOT, sequential run, priority, alignment, wrap, hazard, REDIR, WAIT paths.
    vecs[0]  = mk(0, 0, 0, 0, 0, 1, 32'h3000, 32'h3000, 0, 0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'h3000, 32'h3004, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h3004, 32'h3008, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 32'h3008, 32'h300C, 0, 1, 0);
    vecs[4]  = mk(0, 1, 32'h400, 1, 32'h800, 1, 32'h300C, 32'h400, 0, 1, 1);
    vecs[5]  = mk(0, 1, 32'h403, 0, 0, 1, 32'h400, 32'h400, 0, 1, 1);
    vecs[6]  = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h400, 32'hFFFF_FFFC, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 0, 1, 0);
    vecs[8]  = mk(1, 0, 0, 1, 32'h2000, 1, 32'h0, 32'h0, 1, 1, 0);
    vecs[9]  = mk(1, 0, 0, 1, 32'h2000, 1, 32'h0, 32'h0, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 32'h2000, 1, 32'h0, 32'h2000, 0, 1, 1);
    vecs[11] = mk(0, 0, 0, 1, 32'h900, 0, 32'h2000, 32'h2000, 1, 1, 0);
    vecs[12] = mk(0, 1, 32'hA00, 0, 0, 0, 32'h2000, 32'h2000, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 32'h2000, 32'h2000, 1, 1, 0);
    vecs[14] = mk(1, 1, 32'hA00, 0, 0, 1, 32'h2000, 32'h900, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'h900, 32'h904, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 32'h904, 32'h904, 1, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h904, 32'h904, 1, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 32'hB00, 1, 32'h904, 32'hB00, 0, 1, 1);
    vecs[19] = mk(0, 0, 0, 0, 0, 1, 32'hB00, 32'hB04, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 32'hB04, 32'hB04, 1, 1, 0);
    vecs[21] = mk(0, 1, 32'hC00, 0, 0, 0, 32'hB04, 32'hB04, 1, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'hB04, 32'hC00, 0, 1, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 32'hC00, 32'hC04, 0, 1, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d pc_next", c), pc_next, 32'h3000);
      check($sformatf("rst%0d stall_pc", c), 32'(stall_pc), 32'h0);
      check($sformatf("rst%0d imem_req", c), 32'(imem_req), 32'h0);
      check($sformatf("rst%0d flush_d", c), 32'(flush_d), 32'h1);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].hz, vecs[i].jmp, vecs[i].jt, vecs[i].br, vecs[i].bt, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("row%0d pcf", i), pcf, vecs[i].pcf);
      check($sformatf("row%0d pc_next", i), pc_next, vecs[i].pcn);
      check($sformatf("row%0d stall_pc", i), 32'(stall_pc), 32'(vecs[i].stall));
      check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].req));
      check($sformatf("row%0d flush_d", i), 32'(flush_d), 32'(vecs[i].flush));
      check($sformatf("row%0d imem_timeout", i), 32'(imem_timeout), 32'h0);
      @(posedge clk); #1;
    end

    // Timeout: FETCH miss enters WAIT, then four not-ready WAIT cycles set the sticky flag.
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("to_enter stall_pc", 32'(stall_pc), 32'h1);
    @(posedge clk); #1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("to_wait%0d imem_timeout", k), 32'(imem_timeout), 32'(k == 4));
      check($sformatf("to_wait%0d stall_pc", k), 32'(stall_pc), 32'h1);
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    imem_ready = 1'b1;
    #1;
    check("to_ready pc_next", pc_next, 32'hC08);
    check("to_ready stall_pc", 32'(stall_pc), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_sticky imem_timeout", 32'(imem_timeout), 32'h1);
    check("to_sticky pcf", pcf, 32'hC08);
    @(posedge clk); #1;

    // Reset while a redirect is pending: the latched target must be dropped.
    drive(0, 0, 0, 1, 32'hD00, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("redir_pend stall_pc", 32'(stall_pc), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst pc_next", pc_next, 32'h3000);
    check("mid_rst stall_pc", 32'(stall_pc), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    check("post_rst imem_timeout", 32'(imem_timeout), 32'h0);
    check("post_rst imem_req", 32'(imem_req), 32'h0);
    check("post_rst flush_d", 32'(flush_d), 32'h1);
    check("post_rst pcf", pcf, 32'h3000);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_boot pcf", pcf, 32'h3000);
    check("post_boot pc_next", pc_next, 32'h3004);
    check("post_boot flush_d", 32'(flush_d), 32'h0);
    check("post_boot imem_req", 32'(imem_req), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch-stage sequencer that drives the next-PC value and the active-high stall enable of the PC register. That register has no reset and loads its input whenever its enable is low. The block:
- loads the reset vector while in reset;
- handles instruction-memory wait states with a req/ready handshake;
- arbitrates jump/branch redirects against hazard stalls;
- holds a redirect that arrives during a pending fetch until that fetch completes.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded out of reset (bits [1:0] must be 0)
MAX_WAIT, 16, imem wait cycles tolerated before imem_timeout asserts (1..255)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
pcf  input  32  current PC register output
stall_hazard  input  1  load-use stall from hazard unit
jump_d  input  1  jump resolved in decode
jump_target_d  input  32  jump target
branch_taken_d  input  1  taken branch resolved in decode
branch_target_d  input  32  branch target
imem_ready  input  1  instruction memory has data for address pcf this cycle
pc_next  output  32  to PC register data input
stall_pc  output  1  to PC register enable (1 = hold)
imem_req  output  1  fetch request for address pcf
flush_d  output  1  squash the instruction entering decode
imem_timeout  output  1  sticky error flag

Behaviour:
States: BOOT, FETCH, WAIT, REDIR. Outputs are combinational from state and inputs. Registers: state, redir_tgt[31:0], wait_cnt[7:0], imem_timeout.

Reset:
- rst=1 at a posedge gives state<=BOOT, wait_cnt<=0, imem_timeout<=0, redir_tgt<=0.
- Reset mid-fetch or mid-redirect abandons all pending work.

BOOT:
- Outputs: pc_next=RESET_VEC, stall_pc=0, imem_req=0, flush_d=1.
- Next state FETCH. After the first non-reset edge, pcf=RESET_VEC.

Redirect priority: jump_d > branch_taken_d > sequential. Selected target tgt = jump_target_d, else branch_target_d. Bits [1:0] of every pc_next are forced to 0.

FETCH (imem_req=1):
- imem_ready=1, stall_hazard=0:
  - stall_pc=0.
  - pc_next = tgt if redirect, else pcf+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - flush_d = redirect.
  - Stay in FETCH.
- imem_ready=1, stall_hazard=1:
  - stall_pc=1, flush_d=0, pc_next=pcf.
  - Redirect inputs are ignored, because decode is stalled.
  - Stay in FETCH.
- imem_ready=0:
  - stall_pc=1, pc_next=pcf, flush_d=0.
  - If a redirect is present (and stall_hazard=0): redir_tgt<=tgt, go to REDIR.
  - Otherwise go to WAIT.

WAIT (imem_req=1, stall_pc=1 until ready):
- Redirect with stall_hazard=0: latch tgt, go to REDIR.
- imem_ready=1 with no redirect: behaves exactly as FETCH-ready in that cycle, then returns to FETCH.
- imem_ready=1 and redirect in the same cycle: redirect is taken immediately as in FETCH (pc_next=tgt, flush_d=1), then go to FETCH.

REDIR (imem_req=1, stall_pc=1):
- The wrong-path fetch must complete before the PC moves.
- Later redirects are ignored; the first one latched wins.
- On imem_ready=1: pc_next=redir_tgt, stall_pc=0, flush_d=1, go to FETCH. This overrides stall_hazard.

Wait counter and timeout:
- wait_cnt increments each cycle in WAIT or REDIR while imem_ready=0, saturating at 255.
- It clears on any cycle with imem_ready=1.
- When wait_cnt reaches MAX_WAIT, imem_timeout<=1 and stays set until rst.
- Sequencing continues unchanged after a timeout.

Optional Feature:
Macro PC_FETCH_PERF_EN.

Defined:
- Adds output perf_stall_cycles[31:0]: counts cycles with stall_pc=1 outside BOOT.
- Adds output perf_redirects[31:0]: counts cycles with flush_d=1 outside BOOT.
- Both counters clear on rst and wrap at 2^32.

Undefined:
- Neither port nor its counter logic exists.
- All other behaviour is identical.

Test Plan:
- Reset: rst high 3 cycles, RESET_VEC=32'h0000_3000 → stall_pc=0, pc_next=32'h3000 each reset cycle; BOOT flush_d=1; next cycle pcf=32'h3000, imem_req=1.
- Sequential fetch with imem_ready=1: pcf sequence 3000, 3004, 3008. At pcf=32'hFFFF_FFFC → pc_next=0.
- Redirect priority: jump_d=1 (target 32'h400) and branch_taken_d=1 (target 32'h800) in the same cycle, ready=1 → pc_next=32'h400, flush_d=1. A target of 32'h403 → pc_next=32'h400.
- Hazard stall: stall_hazard=1 for 2 cycles with branch_taken_d=1 → stall_pc=1, pc_next=pcf, no flush. Branch taken on the first unstalled cycle.
- Wait-state redirect: ready=0 for 3 cycles; branch to 32'h900 in cycle 1; jump to 32'hA00 in cycle 2 → stall_pc=1 through cycle 3. Cycle 4 ready=1 → pc_next=32'h900, flush_d=1.
- Timeout: MAX_WAIT=4, ready held 0 → imem_timeout=1 after 4 wait cycles and stays 1 after ready returns; clears only on rst.
